// File: rtl/unified_memory.sv
// Unified instruction/data memory.
// Combinational instruction port plus a handshaked data port with a
// configurable read latency, per-byte write enables and sticky error capture
// for misaligned or out-of-range data accesses.
module unified_memory #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int RD_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     PC,
    output logic [DATA_W-1:0]     instruction,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic [ADDR_W-1:0]     err_addr
);

    localparam int NB  = DATA_W / 8;
    localparam int OFS = $clog2(NB);
    localparam int IDX = $clog2(DEPTH_WORDS);

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_BUSY = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [IDX-1:0]    d_idx;
    logic [IDX-1:0]    pc_idx;
    logic              d_misaligned;
    logic              d_oor;
    logic              d_bad;
    logic              pc_oor;
    logic              accept;
    logic              rd_accept;
    logic              wr_accept;
    logic [DATA_W-1:0] rd_word;

    // Read pipeline: stage_* is the input of each stage, *_q its register.
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] stage_vld;
    logic [DATA_W-1:0] dat_q     [RD_LAT];
    logic [DATA_W-1:0] stage_dat [RD_LAT];

    assign d_idx        = IDX'(d_addr >> OFS);
    assign pc_idx       = IDX'(PC >> OFS);
    assign d_misaligned = (d_addr & ALIGN_MASK) != '0;
    assign d_oor        = (d_addr >> (OFS + IDX)) != '0;
    assign pc_oor       = (PC >> (OFS + IDX)) != '0;
    assign d_bad        = d_misaligned || d_oor;

    assign d_ready   = (state_q == IDLE);
    assign accept    = d_req && d_ready;
    assign rd_accept = accept && !d_we;
    assign wr_accept = accept && d_we && !d_bad;

    // A bad read returns zero rather than whatever word the index aliases to.
    assign rd_word     = d_bad ? '0 : mem[d_idx];
    assign instruction = pc_oor ? '0 : mem[pc_idx];

    // Byte-lane write into the array; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            for (int i = 0; i < NB; i++) begin
                if (d_be[i]) begin
                    mem[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                assign stage_vld[gi] = rd_accept;
                assign stage_dat[gi] = rd_word;
            end else begin : g_body
                assign stage_vld[gi] = vld_q[gi-1];
                assign stage_dat[gi] = dat_q[gi-1];
            end

            // Advance one pipeline stage; data only moves with a valid token so
            // the last stage holds d_rdata until the next return.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q[gi] <= 1'b0;
                    dat_q[gi] <= '0;
                end else begin
                    vld_q[gi] <= stage_vld[gi];
                    if (stage_vld[gi]) begin
                        dat_q[gi] <= stage_dat[gi];
                    end
                end
            end
        end
    endgenerate

    assign d_rvalid = vld_q[RD_LAT-1];
    assign d_rdata  = dat_q[RD_LAT-1];

    // Busy while a multi-cycle read is in flight; free again as the data lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_accept && (RD_LAT > 1)) state_d = RD_BUSY;
            RD_BUSY: if (stage_vld[RD_LAT-1])       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky error flag; the address is captured only for the first offender.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (accept && d_bad) begin
            err_q <= 1'b1;
            if (!err_q) begin
                err_addr_q <= d_addr;
            end
        end
    end

    assign d_err    = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_unified_memory.sv
// Directed testbench for unified_memory: three instances (read latency 1, 3
// and 4) share the address/data/PC buses and reset, each with its own d_req.
module tb_unified_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req1, req3, req4;

    logic [31:0] instr1, instr3, instr4;
    logic        ready1, ready3, ready4;
    logic        rvalid1, rvalid3, rvalid4;
    logic [31:0] rdata1, rdata3, rdata4;
    logic        err1, err3, err4;
    logic [31:0] eaddr1, eaddr3, eaddr4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    unified_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(4096), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .PC(pc), .instruction(instr1),
        .d_req(req1), .d_we(we), .d_be(be), .d_addr(addr), .d_wdata(wdata),
        .d_ready(ready1), .d_rvalid(rvalid1), .d_rdata(rdata1),
        .d_err(err1), .err_addr(eaddr1)
    );

    unified_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(4096), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .PC(pc), .instruction(instr3),
        .d_req(req3), .d_we(we), .d_be(be), .d_addr(addr), .d_wdata(wdata),
        .d_ready(ready3), .d_rvalid(rvalid3), .d_rdata(rdata3),
        .d_err(err3), .err_addr(eaddr3)
    );

    unified_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(4096), .RD_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset), .PC(pc), .instruction(instr4),
        .d_req(req4), .d_we(we), .d_be(be), .d_addr(addr), .d_wdata(wdata),
        .d_ready(ready4), .d_rvalid(rvalid4), .d_rdata(rdata4),
        .d_err(err4), .err_addr(eaddr4)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        e_ready;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_err;
        logic [31:0] e_eaddr;
        logic        chk_i;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] p, input logic ery,
                                input logic erv, input logic [31:0] erd,
                                input logic eer, input logic [31:0] eea,
                                input logic ci, input logic [31:0] ei);
        vec_t v;
        v.req = r; v.we = w; v.be = b; v.addr = a; v.wdata = wd; v.pc = p;
        v.e_ready = ery; v.e_rvalid = erv; v.e_rdata = erd;
        v.e_err = eer; v.e_eaddr = eea; v.chk_i = ci; v.e_instr = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    initial begin
        // Inputs of cycle n; expected outputs observed during cycle n (RD_LAT = 1).
        //            req we be    addr          wdata         pc            rdy rv rdata         err eaddr  ci instr
        vecs[0]  = mk(1, 1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h10,       1, 0, 32'h0,        0, 32'h0,  0, 32'h0);
        vecs[1]  = mk(1, 0, 4'h0, 32'h10,       32'h0,        32'h10,       1, 0, 32'h0,        0, 32'h0,  1, 32'hDEADBEEF);
        vecs[2]  = mk(1, 1, 4'hF, 32'h20,       32'h11223344, 32'h10,       1, 1, 32'hDEADBEEF, 0, 32'h0,  1, 32'hDEADBEEF);
        vecs[3]  = mk(1, 1, 4'h5, 32'h20,       32'hAABBCCDD, 32'h20,       1, 0, 32'hDEADBEEF, 0, 32'h0,  1, 32'h11223344);
        vecs[4]  = mk(1, 0, 4'h0, 32'h20,       32'h0,        32'h20,       1, 0, 32'hDEADBEEF, 0, 32'h0,  1, 32'h11BB33DD);
        vecs[5]  = mk(1, 1, 4'hF, 32'h40,       32'h5A5A5A5A, 32'h20,       1, 1, 32'h11BB33DD, 0, 32'h0,  1, 32'h11BB33DD);
        vecs[6]  = mk(1, 1, 4'h0, 32'h10,       32'h0,        32'h40,       1, 0, 32'h11BB33DD, 0, 32'h0,  1, 32'h5A5A5A5A);
        vecs[7]  = mk(1, 1, 4'hF, 32'h42,       32'hFFFFFFFF, 32'h10,       1, 0, 32'h11BB33DD, 0, 32'h0,  1, 32'hDEADBEEF);
        vecs[8]  = mk(0, 0, 4'h0, 32'h0,        32'h0,        32'h40,       1, 0, 32'h11BB33DD, 1, 32'h42, 1, 32'h5A5A5A5A);
        vecs[9]  = mk(1, 0, 4'h0, 32'h00010000, 32'h0,        32'h40,       1, 0, 32'h11BB33DD, 1, 32'h42, 1, 32'h5A5A5A5A);
        vecs[10] = mk(0, 0, 4'h0, 32'h0,        32'h0,        32'h00010000, 1, 1, 32'h0,        1, 32'h42, 1, 32'h0);
        vecs[11] = mk(1, 0, 4'h0, 32'h40,       32'h0,        32'h42,       1, 0, 32'h0,        1, 32'h42, 1, 32'h5A5A5A5A);
        vecs[12] = mk(1, 1, 4'hF, 32'h00010010, 32'hFFFFFFFF, 32'h00010010, 1, 1, 32'h5A5A5A5A, 1, 32'h42, 1, 32'h0);
        vecs[13] = mk(0, 0, 4'h0, 32'h0,        32'h0,        32'h10,       1, 0, 32'h5A5A5A5A, 1, 32'h42, 1, 32'hDEADBEEF);

        reset = 1'b1; req1 = 0; req3 = 0; req4 = 0;
        we = 0; be = 0; addr = 0; wdata = 0; pc = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.ready3",  ready3,  1);
        check("rst.rvalid3", rvalid3, 0);
        check("rst.rdata3",  rdata3,  0);
        check("rst.err3",    err3,    0);
        check("rst.eaddr3",  eaddr3,  0);
        $display("reset: ready=%0d rvalid=%0d rdata=%08h err=%0d", ready3, rvalid3, rdata3, err3);

        // Table-driven sequence on the single-cycle instance.
        for (int i = 0; i < NV; i++) begin
            req1 = vecs[i].req; we = vecs[i].we; be = vecs[i].be;
            addr = vecs[i].addr; wdata = vecs[i].wdata; pc = vecs[i].pc;
            #1;
            check($sformatf("v%0d.ready", i),  ready1,  vecs[i].e_ready);
            check($sformatf("v%0d.rvalid", i), rvalid1, vecs[i].e_rvalid);
            check($sformatf("v%0d.rdata", i),  rdata1,  vecs[i].e_rdata);
            check($sformatf("v%0d.err", i),    err1,    vecs[i].e_err);
            check($sformatf("v%0d.eaddr", i),  eaddr1,  vecs[i].e_eaddr);
            if (vecs[i].chk_i) check($sformatf("v%0d.instr", i), instr1, vecs[i].e_instr);
            $display("vec %0d: req=%0d we=%0d be=%h addr=%08h pc=%08h -> rvalid=%0d rdata=%08h err=%0d instr=%08h",
                     i, req1, we, be, addr, pc, rvalid1, rdata1, err1, instr1);
            @(negedge clk);
        end
        req1 = 0;

        // RD_LAT = 3: ready drops for two cycles, a held request waits for it.
        req3 = 1; we = 1; be = 4'hF; addr = 32'h40; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        addr = 32'h44; wdata = 32'h0;
        @(negedge clk);
        we = 0; addr = 32'h40; pc = 32'h44;
        #1 check("l3.ready_acc", ready3, 1);
        $display("lat3: read 0x40 presented, ready=%0d", ready3);
        @(negedge clk);
        req3 = 0;
        #1 check("l3.ready_k1", ready3, 0);
        check("l3.rvalid_k1", rvalid3, 0);
        @(negedge clk);
        req3 = 1; we = 1; be = 4'hF; addr = 32'h44; wdata = 32'h77777777;
        #1 check("l3.ready_k2", ready3, 0);
        check("l3.rvalid_k2", rvalid3, 0);
        @(negedge clk);
        #1 check("l3.ready_k3", ready3, 1);
        check("l3.rvalid_k3", rvalid3, 1);
        check("l3.rdata_k3", rdata3, 32'h5A5A5A5A);
        check("l3.instr_pend", instr3, 32'h0);
        $display("lat3: rvalid=%0d rdata=%08h ready=%0d", rvalid3, rdata3, ready3);
        @(negedge clk);
        req3 = 0;
        #1 check("l3.instr_wr", instr3, 32'h77777777);
        check("l3.rvalid_after", rvalid3, 0);
        check("l3.rdata_hold", rdata3, 32'h5A5A5A5A);
        check("l3.ready_after", ready3, 1);
        $display("lat3: held write accepted, instr=%08h", instr3);

        // RD_LAT = 4: reset one cycle after a read accept discards the read.
        req4 = 1; we = 1; be = 4'hF; addr = 32'h80; wdata = 32'hCAFEF00D;
        @(negedge clk);
        we = 0;
        #1 check("l4.ready_acc", ready4, 1);
        @(negedge clk);
        req4 = 0; reset = 1;
        #1 check("l4.ready_busy", ready4, 0);
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("l4.norv%0d", c), rvalid4, 0);
            check($sformatf("l4.ready%0d", c), ready4, 1);
            @(negedge clk);
        end
        check("l4.err", err4, 0);
        check("rst.err1_clr", err1, 0);
        check("rst.eaddr1_clr", eaddr1, 0);
        $display("lat4: reset mid-read, no return seen, err1=%0d", err1);

        req4 = 1; we = 0; addr = 32'h80;
        @(negedge clk);
        req4 = 0;
        begin
            int j;
            bit seen;
            seen = 0;
            j = 1;
            for (int t = 0; t < 12 && !seen; t++) begin
                #1;
                if (rvalid4) seen = 1;
                else begin
                    j++;
                    @(negedge clk);
                end
            end
            check("l4.seen", seen, 1);
            check("l4.latency", j, 4);
            check("l4.rdata", rdata4, 32'hCAFEF00D);
            $display("lat4: readback after %0d cycles rdata=%08h", j, rdata4);
        end
        @(negedge clk);

        // Reset and a write request at the same edge: the write is dropped.
        req1 = 1; we = 1; be = 4'hF; addr = 32'h10; wdata = 32'h0; reset = 1;
        @(negedge clk);
        reset = 0; req1 = 0; pc = 32'h10;
        #1 check("rstwr.instr", instr1, 32'hDEADBEEF);
        check("rstwr.err", err1, 0);
        $display("reset+write: instr@0x10=%08h", instr1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unified_memory.md
# unified_memory

Parametrised successor to the single-cycle unified instruction/data memory. It has a combinational instruction read port and a handshaked data port. The data port adds configurable read latency, per-byte write enables and sticky error capture for misaligned or out-of-range accesses. It sits between the CPU core (fetch stage and load/store unit) and the simulated backing store, and is the memory model used by all multicycle and pipelined CPU variants.

## Interface
- DATA_W, 32: word width in bits; multiple of 8; byte lanes NB = DATA_W/8, OFS = log2(NB)
- ADDR_W, 32: byte-address width on both ports
- DEPTH_WORDS, 4096: number of words; power of two; IDX = log2(DEPTH_WORDS)
- RD_LAT, 1: data-read latency in cycles, legal 1..4
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears control state, not memory contents
- PC  in  ADDR_W  instruction byte address
- instruction  out  DATA_W  combinational instruction word
- d_req  in  1  data request valid
- d_we  in  1  1 = write, 0 = read
- d_be  in  NB  byte-lane write enables; ignored for reads
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data, lane i = bits [8i+7:8i]
- d_ready  out  1  request accepted when d_req && d_ready at a rising edge
- d_rvalid  out  1  one-cycle pulse, d_rdata valid
- d_rdata  out  DATA_W  read data
- d_err  out  1  sticky error flag
- err_addr  out  ADDR_W  d_addr of the first erroring request since reset

## Operation
- Word index = addr[OFS+IDX-1:OFS]. An address is misaligned if addr[OFS-1:0] != 0. It is out of range if any addr bit at or above OFS+IDX is set.
- Instruction port: instruction = mem[index(PC)], purely combinational. If PC is out of range, the port returns 0. Misaligned PC is truncated silently. The instruction port never sets d_err.
- FSM states: IDLE and RD_BUSY.
  - d_ready = 1 in IDLE.
  - IDLE -> RD_BUSY on an accepted read when RD_LAT > 1.
  - RD_BUSY -> IDLE on the cycle d_rvalid asserts.
  - With RD_LAT = 1, the FSM never leaves IDLE.
- Accepted write: at the accept edge, each lane i with d_be[i] = 1 is updated. Lanes with d_be[i] = 0 are unchanged. d_be = 0 is a legal no-op write. A write produces no d_rvalid.
- Accepted read: memory content is sampled at the accept edge and carried through a RD_LAT-stage pipeline. The returned data reflects all writes accepted before that edge.
- Error access (misaligned or out of range):
  - The request is accepted normally.
  - A write is suppressed entirely.
  - A read returns d_rdata = 0 with normal latency and pulse.
  - d_err is set at the accept edge.
  - err_addr is loaded only if d_err was 0, so it holds the first offending address.
- d_err and err_addr clear only on reset.
- Instruction-port reads see a write from the cycle after its accept edge.

## Timing
- Reset values: d_ready = 1, d_rvalid = 0, d_rdata = 0, d_err = 0, err_addr = 0, FSM = IDLE. Memory contents are retained.
- Read latency: for a read accepted at edge k, d_rvalid = 1 for exactly the cycle after edge k+RD_LAT-1. d_rdata is held until the next d_rvalid.
- d_ready is low for the RD_LAT-1 cycles after a read accept. It is high again in the d_rvalid cycle, so a new request may be accepted at the edge ending that cycle. Read throughput is 1 per RD_LAT cycles.
- Writes complete at the accept edge and never drop d_ready. Back-to-back writes are sustained at 1 per cycle.
- While d_ready = 0, d_req is ignored. Requesters must hold the request until it is accepted.
- Reset asserted mid-read: the in-flight read is discarded, no d_rvalid is produced, and d_ready = 1 in the cycle after the reset edge.
- Reset and d_req at the same edge: reset wins and the request is not accepted. A write is not performed.

## Test plan
- RD_LAT = 1: write 0xDEADBEEF to 0x10 with be = 0xF, then read 0x10 in the next cycle. Required: d_rvalid in the following cycle, d_rdata = 0xDEADBEEF, d_ready always 1.
- Byte enables: write 0x11223344 to 0x20 with be = 0xF, then 0xAABBCCDD with be = 0x5, then read 0x20. Required: d_rdata = 0x11BB33DD. PC = 0x20 also shows 0x11BB33DD.
- RD_LAT = 3: read 0x40 (holds 0x5A5A5A5A) accepted at edge k.
  - d_ready = 0 for the 2 cycles after edge k.
  - d_rvalid and d_ready are both 1 in the cycle after edge k+2.
  - A request held since edge k+1 is accepted only at the edge ending that cycle.
- Errors:
  - Write 0xFFFFFFFF to 0x42 (misaligned). Required: memory unchanged, d_err = 1, err_addr = 0x42.
  - Then read 0x00010000 (out of range, DEPTH_WORDS = 4096). Required: d_rdata = 0 with pulse, err_addr still 0x42.
  - Then PC = 0x00010000. Required: instruction = 0.
- Reset mid-read (RD_LAT = 4): assert reset 1 cycle after a read accept. Required: no d_rvalid, d_ready = 1, d_err = 0, and previously written data still readable afterwards.
